// File: rtl/mskaes_32bits_inv_state_datapath_pkg.sv
// rtl/mskaes_32bits_inv_state_datapath_pkg.sv - shared types, limits and GF(2^8) helpers for the masked inverse AES state datapath
package mskaes_32bits_inv_state_datapath_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

    localparam int NROUNDS = 10;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 8;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/mskaes_32bits_inv_state_datapath_inv_mc.sv
// rtl/mskaes_32bits_inv_state_datapath_inv_mc.sv - share-wise InvMixColumns on one shared column
// InvMixColumns is linear, so applying it to each share independently keeps the sharing intact.
module mskaes_32bits_inv_state_datapath_inv_mc
    import mskaes_32bits_inv_state_datapath_pkg::*;
#(
    parameter int d = 2
) (
    input  logic [32*d-1:0] sh_col,
    output logic [32*d-1:0] sh_col_mc
);

    for (genvar s = 0; s < d; s++) begin : g_share
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;

        assign a0 = sh_col[8*d*0 + 8*s +: 8];
        assign a1 = sh_col[8*d*1 + 8*s +: 8];
        assign a2 = sh_col[8*d*2 + 8*s +: 8];
        assign a3 = sh_col[8*d*3 + 8*s +: 8];

        assign sh_col_mc[8*d*0 + 8*s +: 8] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
        assign sh_col_mc[8*d*1 + 8*s +: 8] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
        assign sh_col_mc[8*d*2 + 8*s +: 8] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
        assign sh_col_mc[8*d*3 + 8*s +: 8] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
    end

endmodule

// File: rtl/mskaes_32bits_inv_state_datapath.sv
// rtl/mskaes_32bits_inv_state_datapath.sv - column-serial masked AES-128 decryption state datapath around an external inverse Sbox
module mskaes_32bits_inv_state_datapath
    import mskaes_32bits_inv_state_datapath_pkg::*;
#(
    parameter int d   = 2,
    parameter int LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [128*d-1:0]  sh_ciphertext,
    output logic              key_req,
    output logic [3:0]        key_rnd,
    output logic [1:0]        key_col,
    input  logic [32*d-1:0]   sh_4bytes_from_key,
    output logic              sb_issue,
    output logic [32*d-1:0]   sh_4bytes_to_SB,
    input  logic [32*d-1:0]   sh_4bytes_from_SB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [128*d-1:0]  sh_plaintext
);

    localparam int SW = 8*d;
    localparam int CW = 32*d;
    localparam int BW = 128*d;

    if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
        $error("LAT out of supported range");
    end

    fsm_state_t      fsm_q, fsm_d;
    logic [3:0]      pass_q, pass_d;
    logic [1:0]      col_q, col_d;
    logic            waiting_q, waiting_d;
    logic [2:0]      wait_q, wait_d;
    logic            load;
    logic            commit;
    logic            final_xor;

    logic [BW-1:0]   state_q;
    logic [BW-1:0]   acc_q;
    logic [BW-1:0]   acc_wb;
    logic [LAT-1:0]  tag_v_q;
    logic [LAT-1:0][1:0] tag_c_q;
    logic            rb_v;
    logic [1:0]      rb_col;

    logic [CW-1:0]   cur_col;
    logic [CW-1:0]   key_x;
    logic [CW-1:0]   mc_col;

    assign cur_col = state_q[CW*int'(col_q) +: CW];
    assign key_x   = cur_col ^ sh_4bytes_from_key;

    mskaes_32bits_inv_state_datapath_inv_mc #(
        .d (d)
    ) u_inv_mc (
        .sh_col    (key_x),
        .sh_col_mc (mc_col)
    );

    assign sh_4bytes_to_SB = (pass_q == 4'd0) ? key_x : mc_col;
    assign sh_plaintext    = state_q;

    assign rb_v   = tag_v_q[LAT-1];
    assign rb_col = tag_c_q[LAT-1];

    // Results land in a shadow copy so that, for short Sbox latencies, writebacks
    // never disturb columns of the current pass that are still waiting to be issued.
    always_comb begin
        logic [1:0] dst;
        acc_wb = acc_q;
        dst    = 2'd0;
        if (rb_v) begin
            for (int r = 0; r < 4; r++) begin
                dst = rb_col + 2'(r);
                acc_wb[CW*int'(dst) + SW*r +: SW] = sh_4bytes_from_SB[SW*r +: SW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= ST_IDLE;
            pass_q    <= 4'd0;
            col_q     <= 2'd0;
            waiting_q <= 1'b0;
            wait_q    <= 3'd0;
        end else begin
            fsm_q     <= fsm_d;
            pass_q    <= pass_d;
            col_q     <= col_d;
            waiting_q <= waiting_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        pass_d    = pass_q;
        col_d     = col_q;
        waiting_d = waiting_q;
        wait_d    = wait_q;
        in_ready  = 1'b0;
        key_req   = 1'b0;
        key_rnd   = 4'd0;
        key_col   = col_q;
        sb_issue  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        commit    = 1'b0;
        final_xor = 1'b0;
        unique case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    fsm_d     = ST_PASS;
                    pass_d    = 4'd0;
                    col_d     = 2'd0;
                    waiting_d = 1'b0;
                    wait_d    = 3'd0;
                end
            end
            ST_PASS: begin
                if (!waiting_q) begin
                    key_req  = 1'b1;
                    sb_issue = 1'b1;
                    key_rnd  = 4'(NROUNDS) - pass_q;
                    if (col_q == 2'd3) begin
                        waiting_d = 1'b1;
                        wait_d    = 3'd0;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else if (wait_q == 3'(LAT-1)) begin
                    // The last column of this pass returns in this very cycle.
                    commit    = 1'b1;
                    col_d     = 2'd0;
                    waiting_d = 1'b0;
                    if (pass_q == 4'(NROUNDS-1)) begin
                        fsm_d = ST_FINAL;
                    end else begin
                        pass_d = pass_q + 4'd1;
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            ST_FINAL: begin
                key_req   = 1'b1;
                key_rnd   = 4'd0;
                final_xor = 1'b1;
                col_d     = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v_q <= '0;
            tag_c_q <= '0;
        end else begin
            tag_v_q[0] <= sb_issue;
            tag_c_q[0] <= col_q;
            for (int i = 1; i < LAT; i++) begin
                tag_v_q[i] <= tag_v_q[i-1];
                tag_c_q[i] <= tag_c_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_wb;
        if (load) begin
            state_q <= sh_ciphertext;
        end else if (commit) begin
            state_q <= acc_wb;
        end else if (final_xor) begin
            state_q[CW*int'(col_q) +: CW] <= key_x;
        end
    end

endmodule

// File: tb/tb_mskaes_32bits_inv_state_datapath.sv
// tb/tb_mskaes_32bits_inv_state_datapath.sv - directed bench for three Sbox latencies with a masked inverse-Sbox and key-column model
module tb_mskaes_32bits_inv_state_datapath;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic out_ready;
    logic [255:0] sh_ct;
    logic key_sel;
    int   cyc = 0;
    int   errors;
    int   checks;

    logic [2:0]   in_ready_v;
    logic [2:0]   out_valid_v;
    logic [2:0]   key_req_v;
    logic [2:0]   sb_issue_v;
    logic [3:0]   key_rnd_v [3];
    logic [1:0]   key_col_v [3];
    logic [255:0] pt_v [3];

    logic [7:0]  sb [256];
    logic [7:0]  inv_sb [256];
    logic [31:0] rk_w [2][64];

    localparam int LATS [3] = '{4, 1, 8};

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [63:0] share_word(input logic [31:0] w, input logic [31:0] m);
        logic [63:0] o;
        for (int r = 0; r < 4; r++) begin
            o[16*r +: 8]   = w[31-8*r -: 8] ^ m[8*r +: 8];
            o[16*r+8 +: 8] = m[8*r +: 8];
        end
        return o;
    endfunction

    function automatic logic [63:0] sbox_model(input logic [63:0] x);
        logic [63:0] o;
        logic [7:0] m;
        for (int r = 0; r < 4; r++) begin
            m = 8'($urandom_range(0, 255));
            o[16*r +: 8]   = inv_sb[x[16*r +: 8] ^ x[16*r+8 +: 8]] ^ m;
            o[16*r+8 +: 8] = m;
        end
        return o;
    endfunction

    function automatic logic [255:0] share128(input logic [127:0] v);
        logic [255:0] o;
        logic [7:0] m;
        for (int i = 0; i < 16; i++) begin
            m = 8'($urandom_range(0, 255));
            o[16*i +: 8]   = v[127-8*i -: 8] ^ m;
            o[16*i+8 +: 8] = m;
        end
        return o;
    endfunction

    function automatic logic [127:0] unshare128(input logic [255:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[16*i +: 8] ^ s[16*i+8 +: 8];
        return o;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LV = LATS[g];
        logic [63:0] to_sb;
        logic [63:0] from_sb;
        logic [63:0] from_key;
        logic [63:0] pipe [LV];

        mskaes_32bits_inv_state_datapath #(
            .d   (2),
            .LAT (LV)
        ) u_dut (
            .clk                (clk),
            .rst                (rst),
            .in_valid           (in_valid),
            .in_ready           (in_ready_v[g]),
            .sh_ciphertext      (sh_ct),
            .key_req            (key_req_v[g]),
            .key_rnd            (key_rnd_v[g]),
            .key_col            (key_col_v[g]),
            .sh_4bytes_from_key (from_key),
            .sb_issue           (sb_issue_v[g]),
            .sh_4bytes_to_SB    (to_sb),
            .sh_4bytes_from_SB  (from_sb),
            .out_valid          (out_valid_v[g]),
            .out_ready          (out_ready),
            .sh_plaintext       (pt_v[g])
        );

        assign from_key = share_word(rk_w[key_sel][{key_rnd_v[g], key_col_v[g]}],
                                     32'h9e37_79b9 ^ {26'd0, key_rnd_v[g], key_col_v[g]});
        assign from_sb  = pipe[LV-1];

        always @(posedge clk) begin
            pipe[0] <= sbox_model(to_sb);
            for (int i = 1; i < LV; i++) pipe[i] <= pipe[i-1];
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expand(input logic [127:0] key, input int ks);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) rk_w[ks][i] = w[i];
    endtask

    // One full decryption on all three instances; out_ready stays low until the slowest one is done.
    task automatic run_vec(input string tag, input logic [127:0] ct, input logic [127:0] exp,
                           output logic [255:0] pt0, output logic [255:0] ct_sh);
        int done [3];
        int t_hs, lat, kcnt, kbad, icnt, er, ec;
        bit rdy_seen;
        logic [255:0] pt_first;
        done = '{-1, -1, -1};
        kcnt = 0; kbad = 0; icnt = 0; rdy_seen = 0; pt_first = '0;
        @(negedge clk);
        sh_ct = share128(ct);
        ct_sh = sh_ct;
        in_valid = 1'b1;
        @(posedge clk); #1;
        t_hs = cyc;
        in_valid = 1'b0;
        for (int n = 0; n < 400 && (done[0] < 0 || done[1] < 0 || done[2] < 0); n++) begin
            @(negedge clk);
            lat = cyc - t_hs + 1;
            if (lat == 90) begin
                in_valid = 1'b1;
                sh_ct = ~sh_ct;
            end
            if (lat == 110) in_valid = 1'b0;
            if (key_req_v[0]) begin
                er = (kcnt < 40) ? 10 - kcnt / 4 : 0;
                ec = (kcnt < 40) ? kcnt % 4 : kcnt - 40;
                if (kcnt >= 44 || int'(key_rnd_v[0]) != er || int'(key_col_v[0]) != ec) kbad++;
                kcnt++;
            end
            if (sb_issue_v[0]) icnt++;
            if (in_ready_v[0]) rdy_seen = 1;
            for (int k = 0; k < 3; k++) begin
                if (out_valid_v[k] && done[k] < 0) begin
                    done[k] = lat;
                    if (k == 0) pt_first = pt_v[0];
                end
            end
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_latency_lat%0d", tag, LATS[k]), 256'(done[k]), 256'(5 + 10 * (4 + LATS[k])));
            chk($sformatf("%s_plaintext_lat%0d", tag, LATS[k]), 256'(unshare128(pt_v[k])), 256'(exp));
        end
        chk({tag, "_key_trace"}, {224'(kbad), 32'(kcnt)}, {224'd0, 32'd44});
        chk({tag, "_sb_issue_count"}, 256'(icnt), 256'd40);
        chk({tag, "_in_ready_low"}, 256'(rdy_seen), 256'd0);
        chk({tag, "_out_valid_held"}, 256'(out_valid_v[0]), 256'd1);
        chk({tag, "_plaintext_stable"}, pt_v[0], pt_first);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_release_out_valid"}, 256'(out_valid_v), 256'd0);
        chk({tag, "_release_in_ready"}, 256'(in_ready_v), 256'b111);
        pt0 = pt_first;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   p, b;
        logic [255:0] pa, pb, ca, cb, pc, cc;
        errors = 0; checks = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sh_ct = '0; key_sel = 1'b0;

        for (int x = 0; x < 256; x++) begin
            p = 8'h01;
            for (int i = 0; i < 254; i++) p = gm(p, 8'(x));
            b = (x == 0) ? 8'h00 : p;
            sb[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_sb[sb[x]] = 8'(x);
        expand(128'h000102030405060708090a0b0c0d0e0f, 0);
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 256'(in_ready_v), 256'b111);
        chk("reset_out_valid", 256'(out_valid_v), 256'd0);
        chk("reset_sb_issue", 256'(sb_issue_v), 256'd0);
        chk("reset_key_req", 256'(key_req_v), 256'd0);
        rst = 1'b0;

        run_vec("fips_c1", 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff, pa, ca);
        run_vec("fips_c1_remask", 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff, pb, cb);
        chk("remask_ct_shares_differ", 256'(ca == cb), 256'd0);
        chk("remask_pt_shares_differ", 256'(pa == pb), 256'd0);

        key_sel = 1'b1;
        @(negedge clk);
        sh_ct = share128(128'h3925841d02dc09fbdc118597196a0b32);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 256'(in_ready_v), 256'b111);
        chk("abort_out_valid", 256'(out_valid_v), 256'd0);
        chk("abort_sb_issue", 256'(sb_issue_v), 256'd0);
        chk("abort_key_req", 256'(key_req_v), 256'd0);

        run_vec("fips_b", 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734, pc, cc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
